// File: rtl/gf_vme_reg_master.sv
// gf_vme_reg_master: single-word initiator for the GigaFitter internal register bus.
// Turns one read/write command into an address/strobe sequence for the register responders.
// A write drives the data bus for WR_HOLD cycles while writeRegister is high. A read holds
// readRegister for RD_WAIT cycles and samples the bus on the last edge. Every access then
// idles the strobes for GAP cycles, which releases the responder write veto.
// Optional build macro GF_VME_MASTER_RDBACK_EN: each write is followed by a read-back of the
// same address, and rsp_err flags a mismatch between written and read-back data.
module gf_vme_reg_master #(
   parameter int unsigned WR_HOLD = 3,
   parameter int unsigned RD_WAIT = 2,
   parameter int unsigned GAP     = 1
) (
   input  logic        clk,
   input  logic        init_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic        rsp_write,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic [15:0] address,
   output logic        writeRegister,
   output logic        readRegister,
   inout  wire  [31:0] data
);

   // Duration counter reload values: each phase lasts (reload + 1) cycles.
   localparam logic [3:0] WR_CNT  = 4'(WR_HOLD - 1);
   localparam logic [3:0] RD_CNT  = 4'(RD_WAIT - 1);
   localparam logic [3:0] GAP_CNT = 4'(GAP - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_RD   = 3'd2,
      ST_REC  = 3'd3
`ifdef GF_VME_MASTER_RDBACK_EN
      ,
      ST_VRD  = 3'd4,
      ST_VREC = 3'd5
`endif
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [15:0] addr_q;
   logic [31:0] wdata_q;
   logic        write_q;
   logic        wr_stb_q;
   logic        rd_stb_q;
   logic        data_oe;
   logic        busy_q;
   logic        rsp_valid_q;
   logic        rsp_write_q;
   logic [31:0] rsp_rdata_q;
   logic        accept_d;
   logic        cnt_done_d;

   assign accept_d   = cmd_valid && !busy_q && (state_q == ST_IDLE);
   assign cnt_done_d = (cnt_q == 4'd0);

   // Access sequencer: every bus-facing output is a flop written only here.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= 16'd0;
         wdata_q     <= 32'd0;
         write_q     <= 1'b0;
         wr_stb_q    <= 1'b0;
         rd_stb_q    <= 1'b0;
         data_oe     <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
      end else begin
         rsp_valid_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (accept_d) begin
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  write_q <= cmd_write;
                  busy_q  <= 1'b1;
                  if (cmd_write) begin
                     state_q  <= ST_WR;
                     cnt_q    <= WR_CNT;
                     wr_stb_q <= 1'b1;
                     data_oe  <= 1'b1;
                  end else begin
                     state_q  <= ST_RD;
                     cnt_q    <= RD_CNT;
                     rd_stb_q <= 1'b1;
                  end
               end
            end
            ST_WR: begin
               if (cnt_done_d) begin
                  wr_stb_q <= 1'b0;
                  data_oe  <= 1'b0;
                  state_q  <= ST_REC;
                  cnt_q    <= GAP_CNT;
`ifndef GF_VME_MASTER_RDBACK_EN
                  // Without read-back the write is complete once the strobe drops.
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= 1'b1;
`endif
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RD: begin
               if (cnt_done_d) begin
                  rd_stb_q    <= 1'b0;
                  rsp_rdata_q <= data;
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= 1'b0;
                  state_q     <= ST_REC;
                  cnt_q       <= GAP_CNT;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_REC: begin
               if (cnt_done_d) begin
`ifdef GF_VME_MASTER_RDBACK_EN
                  if (write_q) begin
                     // Verify the write by reading the same address back.
                     state_q  <= ST_VRD;
                     cnt_q    <= RD_CNT;
                     rd_stb_q <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
`else
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
`endif
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
`ifdef GF_VME_MASTER_RDBACK_EN
            ST_VRD: begin
               if (cnt_done_d) begin
                  rd_stb_q    <= 1'b0;
                  rsp_rdata_q <= data;
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= 1'b1;
                  state_q     <= ST_VREC;
                  cnt_q       <= GAP_CNT;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_VREC: begin
               if (cnt_done_d) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
`endif
            default: begin
               state_q  <= ST_IDLE;
               busy_q   <= 1'b0;
               wr_stb_q <= 1'b0;
               rd_stb_q <= 1'b0;
               data_oe  <= 1'b0;
            end
         endcase
      end
   end

`ifdef GF_VME_MASTER_RDBACK_EN
   logic rsp_err_q;

   // Read-back comparator: flag the completion pulse when the bus returned other than written.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         rsp_err_q <= 1'b0;
      end else if (state_q == ST_VRD && cnt_done_d) begin
         rsp_err_q <= (data != wdata_q);
      end else if (state_q == ST_RD && cnt_done_d) begin
         rsp_err_q <= 1'b0;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign cmd_ready     = !busy_q;
   assign busy          = busy_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_write     = rsp_write_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign address       = addr_q;
   assign writeRegister = wr_stb_q;
   assign readRegister  = rd_stb_q;
   assign data          = data_oe ? wdata_q : 32'bz;

endmodule

// File: tb/tb_gf_vme_reg_master.sv
// Bench for gf_vme_reg_master: responder model on the shared bus, scoreboard of expected
// completions, and bus-protocol monitors (strobe widths, strobe gaps, overlap, contention).
module tb_gf_vme_reg_master;

   localparam int WR_HOLD = 3;
   localparam int RD_WAIT = 2;
   localparam int GAP     = 1;
   localparam int RD_LAT  = RD_WAIT + 1;
`ifdef GF_VME_MASTER_RDBACK_EN
   localparam int WR_LAT  = WR_HOLD + GAP + RD_WAIT + 1;
   localparam bit WR_CHK  = 1'b1;
`else
   localparam int WR_LAT  = WR_HOLD + 1;
   localparam bit WR_CHK  = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        init_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic [15:0] address;
   logic        writeRegister;
   logic        readRegister;
   wire  [31:0] data;

   gf_vme_reg_master #(.WR_HOLD(WR_HOLD), .RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
      .clk(clk), .init_n(init_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .busy(busy), .address(address), .writeRegister(writeRegister),
      .readRegister(readRegister), .data(data)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // ---------------- responder model ----------------
   // Registers at 0x10/0x20/0x30/0x40; 0x30 has bit 0 stuck at 0.
   logic [31:0] regs [4];
   int          lat_cnt [4];
   int          wcnt;
   int          ridx;
   logic        resp_oe_q;
   logic [31:0] resp_val_q;

   function automatic int idx_of(input logic [15:0] a);
      case (a)
         16'h0010: return 0;
         16'h0020: return 1;
         16'h0030: return 2;
         16'h0040: return 3;
         default:  return -1;
      endcase
   endfunction

   always_comb ridx = idx_of(address);

   assign data = resp_oe_q ? resp_val_q : 32'bz;

   always @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         resp_oe_q  <= 1'b0;
         resp_val_q <= 32'd0;
         wcnt       <= 0;
      end else begin
         resp_oe_q  <= readRegister && (ridx >= 0);
         resp_val_q <= (ridx >= 0) ? regs[ridx[1:0]] : 32'd0;
         if (writeRegister && ridx >= 0) begin
            if (wcnt == 1) begin
               regs[ridx[1:0]]    <= (ridx == 2) ? (data & ~32'd1) : data;
               lat_cnt[ridx[1:0]] <= lat_cnt[ridx[1:0]] + 1;
            end
            wcnt <= (wcnt >= 3) ? 3 : wcnt + 1;
         end else begin
            wcnt <= 0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      bit          w;
      logic [31:0] rd;
      bit          chk_rd;
      bit          err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   int wr_run = 0, rd_run = 0, low_run = 0;
   int last_wr_w = 0, last_rd_w = 0, last_gap = 0;
   int overlap = 0, conflicts = 0;

   // Monitor: protocol observations and completion checking against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (writeRegister && readRegister) overlap++;
      if (writeRegister && resp_oe_q) conflicts++;
      if (writeRegister) wr_run++;
      else if (wr_run != 0) begin last_wr_w = wr_run; wr_run = 0; end
      if (readRegister) rd_run++;
      else if (rd_run != 0) begin last_rd_w = rd_run; rd_run = 0; end
      if (!writeRegister && !readRegister) low_run++;
      else begin
         if (low_run != 0) last_gap = low_run;
         low_run = 0;
      end
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            check_val("spurious_rsp", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check_val("rsp_write", {31'd0, rsp_write}, {31'd0, e.w});
            if (e.chk_rd) check_val("rsp_rdata", rsp_rdata, e.rd);
            check_val("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            check_val("rsp_latency", cyc - e.acc, e.lat);
         end
      end
   end

   // Called at a negedge; returns at the negedge just after the accepting edge.
   task automatic issue(input bit w, input logic [15:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input bit chk_rd, input bit exp_err,
                        input int lat, input bit expect_rsp);
      int   g;
      exp_t e;
      g = 0;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      while (!cmd_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) begin
         check_val("accept_timeout", 32'd0, 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      if (expect_rsp) begin
         e.w = w; e.rd = exp_rd; e.chk_rd = chk_rd; e.err = exp_err; e.lat = lat; e.acc = cyc;
         sb.push_back(e);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((sb.size() != 0 || busy) && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) check_val("drain_timeout", 32'd1, 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 4; i++) begin regs[i] = 32'd0; lat_cnt[i] = 0; end
      init_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'd0; cmd_wdata = 32'd0;
      repeat (3) @(negedge clk);
      check_val("rst_address", {16'd0, address}, 32'd0);
      check_val("rst_wrstb", {31'd0, writeRegister}, 32'd0);
      check_val("rst_rdstb", {31'd0, readRegister}, 32'd0);
      check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      init_n = 1'b1;
      @(negedge clk);
      check_val("rst_ready", {31'd0, cmd_ready}, 32'd1);

      // Single write
      issue(1'b1, 16'h0010, 32'hDEADBEEF, 32'hDEADBEEF, WR_CHK, 1'b0, WR_LAT, 1'b1);
      drain();
      check_val("t1_wr_width", last_wr_w, WR_HOLD);
      check_val("t1_latched", lat_cnt[0], 1);
      check_val("t1_reg", regs[0], 32'hDEADBEEF);

      // Read back the same register
      issue(1'b0, 16'h0010, 32'd0, 32'hDEADBEEF, 1'b1, 1'b0, RD_LAT, 1'b1);
      drain();
      check_val("t2_rd_width", last_rd_w, RD_WAIT);

      // Back-to-back with cmd_valid held
      issue(1'b1, 16'h0020, 32'h12345678, 32'h12345678, WR_CHK, 1'b0, WR_LAT, 1'b1);
      issue(1'b0, 16'h0020, 32'd0, 32'h12345678, 1'b1, 1'b0, RD_LAT, 1'b1);
      drain();
      check_val("t3_latched_once", lat_cnt[1], 1);
      check_val("t3_strobe_gap", last_gap, GAP + 1);

      // Unmapped address
      issue(1'b0, 16'h0FFF, 32'd0, 32'd0, 1'b0, 1'b0, RD_LAT, 1'b1);
      drain();
      check_val("t4_ready", {31'd0, cmd_ready}, 32'd1);

      // Reset during the 2nd write-strobe cycle
      issue(1'b1, 16'h0040, 32'h55AA55AA, 32'd0, 1'b0, 1'b0, 0, 1'b0);
      @(posedge clk);
      #2;
      init_n = 1'b0;
      #1;
      check_val("t5_wrstb_async", {31'd0, writeRegister}, 32'd0);
      check_val("t5_rdstb_async", {31'd0, readRegister}, 32'd0);
      check_val("t5_busy_async", {31'd0, busy}, 32'd0);
      @(negedge clk);
      init_n = 1'b1;
      @(negedge clk);
      check_val("t5_ready", {31'd0, cmd_ready}, 32'd1);
      check_val("t5_no_latch", lat_cnt[3], 0);
      repeat (8) @(negedge clk);
      check_val("t5_queue_empty", sb.size(), 0);

`ifdef GF_VME_MASTER_RDBACK_EN
      // Read-back to a register with a stuck bit
      issue(1'b1, 16'h0030, 32'hA5A5A5A5, 32'hA5A5A5A4, 1'b1, 1'b1, WR_LAT, 1'b1);
      drain();
      issue(1'b1, 16'h0040, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b1, 1'b0, WR_LAT, 1'b1);
      drain();
`endif

      check_val("strobe_overlap", overlap, 0);
      check_val("bus_contention", conflicts, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/gf_vme_reg_master.md
Name: gf_vme_reg_master

Overview:
- Initiator for the GigaFitter internal register bus. It converts single-word read/write commands from the control logic into address/strobe sequences on the shared bus.
- Drives the timing that the per-register responders expect: a registered write pulse, a write veto released on strobe drop, and tri-stated read data enabled one cycle after the read strobe.
- Sits between the VME interface sequencer and the array of register responders on `address`/`data`.

Parameters:
- WR_HOLD, 3, cycles `writeRegister` stays asserted; legal range 2..15 (responder latches data on its 2nd cycle).
- RD_WAIT, 2, cycles `readRegister` stays asserted before `data` is sampled; legal range 2..15.
- GAP, 1, idle cycles after a strobe drops before the next access; legal range 1..15 (the responder keeps driving `data` one cycle after `readRegister` falls).

Ports:
- clk  in  1  system clock, all logic on rising edge
- init_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle and able to accept
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  16  target register address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_write  out  1  echo of the completed op type
- rsp_rdata  out  32  read data (last read); held until the next read completes
- rsp_err  out  1  read-back mismatch (optional feature only; otherwise 0)
- busy  out  1  access in progress (inverse of `cmd_ready`)
- address  out  16  register bus address
- writeRegister  out  1  write strobe
- readRegister  out  1  read strobe
- data  inout  32  shared bus; driven by this block only while the internal `data_oe` is 1, otherwise high-Z

Behaviour:
- Reset (`init_n` = 0, async): FSM goes to IDLE.
  - All outputs are 0: `address`, `writeRegister`, `readRegister`, `rsp_*`, `busy`.
  - `cmd_ready` = 1 once reset is released; `data` is high-Z.
  - Reset mid-access aborts immediately: strobes drop, `data` is released, no `rsp_valid`.
- Accept: a command is taken on an edge where `cmd_valid` && `cmd_ready`. `cmd_addr`, `cmd_wdata` and `cmd_write` are latched internally. `cmd_ready` is 0 from the next cycle until the FSM returns to IDLE.
- FSM states:
  - IDLE: on accept, go to WR_STROBE or RD_STROBE.
  - WR_STROBE (WR_HOLD cycles): `address` = latched addr, `writeRegister` = 1, `data` = latched wdata (`data_oe` = 1). Then go to RECOVER.
  - RD_STROBE (RD_WAIT cycles): `address` = latched addr, `readRegister` = 1, `data_oe` = 0.
    - On the edge ending the last RD_STROBE cycle, `data` is captured into `rsp_rdata`.
    - Then go to RECOVER.
  - RECOVER (GAP cycles): both strobes 0, `data_oe` = 0, `address` held.
    - `rsp_valid` pulses during the first RECOVER cycle with `rsp_write` = op.
    - At the end of RECOVER, go to IDLE.
- Latency from the accept edge to `rsp_valid`:
  - write: WR_HOLD + 1 cycles;
  - read: RD_WAIT + 1 cycles.
- Minimum accept-to-accept spacing: op length + GAP + 1 cycles. Back-to-back commands therefore always see at least one cycle with strobes low, which releases the responder write veto.
- `writeRegister` and `readRegister` are never 1 in the same cycle.
- `data_oe` is never 1 while `readRegister` is 1, nor during RECOVER.
- All bus outputs come directly from flops: no combinational path from `cmd_*` to the bus.
- A `cmd_valid` that arrives while busy is ignored and not queued; the requester must hold it until `cmd_ready`.
- Duration counter: 4 bits, loaded with (param − 1) on each state entry, decrementing to 0. No wrap.

Optional Feature:
- Macro `GF_VME_MASTER_RDBACK_EN`.
- When defined, every write is followed (after its GAP) by an automatic read of the same address:
  - this read uses the RD_STROBE and RECOVER timing;
  - a single `rsp_valid` is issued only after the read-back completes;
  - `rsp_write` = 1, `rsp_rdata` = value read back;
  - `rsp_err` = 1 for that pulse if the read-back value differs from the written data.
- When not defined: `rsp_err` is tied 0, writes complete after a single RECOVER phase, and the verify states and comparator are absent.

Test Plan:
1. Write: addr 0x0010, wdata 0xDEADBEEF, default params, model responder at 0x0010 → `writeRegister` high exactly 3 cycles; responder holds 0xDEADBEEF; `rsp_valid` 4 cycles after accept; `rsp_write` = 1.
2. Read: read 0x0010 after test 1 → `readRegister` high 2 cycles; `rsp_rdata` = 0xDEADBEEF; `rsp_valid` 3 cycles after accept; no bus contention (no X) on `data` in any cycle.
3. Back-to-back: `cmd_valid` held high with write 0x0020 = 0x12345678 then read 0x0020 → at least one strobe-low cycle between accesses; read returns 0x12345678; responder latches exactly once (veto works).
4. Unmapped address: read 0x0FFF with no responder → `data` stays high-Z; `rsp_valid` still fires at 3 cycles; no hang.
5. Reset mid-write: `init_n` driven low during the 2nd WR_STROBE cycle → strobes and `data_oe` drop asynchronously; no `rsp_valid`; `cmd_ready` = 1 after release.
6. `GF_VME_MASTER_RDBACK_EN` defined: write 0x0030 = 0xA5A5A5A5 to a responder whose bit 0 is stuck at 0 → single `rsp_valid`; `rsp_rdata` = 0xA5A5A5A4; `rsp_err` = 1. A healthy responder gives `rsp_err` = 0.
